enable_debounce: RTL and testbench



---
 rtl/fsm_pkg.sv | 11 +
 rtl/sync2.sv | 21 ++
 rtl/enable_debounce.sv | 117 +++++++++++
 tb/tb_enable_debounce.sv | 125 ++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared constants for the enable debounce stage and the enable-driven counter FSM.
package fsm_pkg;

    localparam logic [1:0] STABLE_LO = 2'b00;
    localparam logic [1:0] PEND_HI   = 2'b01;
    localparam logic [1:0] STABLE_HI = 2'b10;
    localparam logic [1:0] PEND_LO   = 2'b11;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/sync2.sv
// Two-flop metastability synchronizer with synchronous active-high reset.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/enable_debounce.sv
// Debounces a raw button into a clean enable level E plus one-cycle rise/fall strobes.
// Define ENABLE_DEBOUNCE_SYNC_EN to put a two-flop synchronizer ahead of the input register.
module enable_debounce
    import fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic E,
    output logic rise,
    output logic fall
);

    localparam int              CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   ONE    = CW'(1);
    localparam bit              NO_PEND = (DEBOUNCE_CYCLES == 1);

    logic          btn_sync;
    logic          s;
    logic [1:0]    state, state_n;
    logic [CW-1:0] count, count_n;
    logic          e_n, rise_n, fall_n;

`ifdef ENABLE_DEBOUNCE_SYNC_EN
    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn),
        .q     (btn_sync)
    );
`else
    assign btn_sync = btn;
`endif

    always_ff @(posedge clk) begin
        if (reset) s <= 1'b0;
        else       s <= btn_sync;
    end

    // count defaults to zero so any cycle with s == E clears it
    always_comb begin
        state_n = state;
        count_n = '0;
        e_n     = E;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            STABLE_LO: begin
                if (s) begin
                    if (NO_PEND) begin
                        state_n = STABLE_HI;
                        e_n     = 1'b1;
                        rise_n  = 1'b1;
                    end else begin
                        state_n = PEND_HI;
                        count_n = ONE;
                    end
                end
            end
            PEND_HI: begin
                if (!s) begin
                    state_n = STABLE_LO;
                end else if (count == LAST) begin
                    state_n = STABLE_HI;
                    e_n     = 1'b1;
                    rise_n  = 1'b1;
                end else begin
                    count_n = count + ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    if (NO_PEND) begin
                        state_n = STABLE_LO;
                        e_n     = 1'b0;
                        fall_n  = 1'b1;
                    end else begin
                        state_n = PEND_LO;
                        count_n = ONE;
                    end
                end
            end
            PEND_LO: begin
                if (s) begin
                    state_n = STABLE_HI;
                end else if (count == LAST) begin
                    state_n = STABLE_LO;
                    e_n     = 1'b0;
                    fall_n  = 1'b1;
                end else begin
                    count_n = count + ONE;
                end
            end
            default: state_n = STABLE_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STABLE_LO;
            count <= '0;
            E     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            E     <= e_n;
            rise  <= rise_n;
            fall  <= fall_n;
        end
    end

endmodule

// File: tb/tb_enable_debounce.sv
// Scoreboard bench for enable_debounce with DEBOUNCE_CYCLES=4; follows ENABLE_DEBOUNCE_SYNC_EN for latency.
module tb_enable_debounce;
    import fsm_pkg::*;

    localparam int DC = 4;
`ifdef ENABLE_DEBOUNCE_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif
    // step index (0 = first edge sampling the new level) at which E changes
    localparam int CHG_AT = DC + EXTRA;

    logic clk = 1'b0;
    logic reset;
    logic btn;
    logic E, rise, fall;

    typedef struct packed {
        logic e;
        logic r;
        logic f;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    enable_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .E     (E),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // drive one cycle and record the outputs expected after that edge
    task automatic step(input logic r, input logic b, input logic e, input logic ri, input logic fa);
        reset = r;
        btn   = b;
        @(posedge clk);
        #1;
        exp_q.push_back('{e: e, r: ri, f: fa});
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("E",    int'(E),    int'(x.e));
            chk("rise", int'(rise), int'(x.r));
            chk("fall", int'(fall), int'(x.f));
        end
    end

    initial begin
        reset = 1'b1;
        btn   = 1'b1;

        // reset held two cycles with btn high
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("state_after_reset", int'(dut.state), int'(STABLE_LO));
        chk("count_after_reset", int'(dut.count), 0);

        // settle low, then rise held 10+ cycles
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 10 + EXTRA; i++)
            step(0, 1, logic'(i >= CHG_AT), logic'(i == CHG_AT), 0);
        chk("state_hi", int'(dut.state), int'(STABLE_HI));

        // fall held low
        for (int i = 0; i < 10 + EXTRA; i++)
            step(0, 0, logic'(i < CHG_AT), 0, logic'(i == CHG_AT));
        chk("state_lo", int'(dut.state), int'(STABLE_LO));

        // bounce: high 3, low 1, high 2, low
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
        chk("state_after_bounce", int'(dut.state), int'(STABLE_LO));

        // toggling every cycle never reaches the threshold
        for (int i = 0; i < 12; i++) step(0, logic'(i % 2 == 0), 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

        // drive into PEND_HI with count=2, then reset
        for (int i = 0; i < 3 + EXTRA; i++) step(0, 1, 0, 0, 0);
        chk("state_pend", int'(dut.state), int'(PEND_HI));
        chk("count_pend", int'(dut.count), 2);
        step(1, 1, 0, 0, 0);
        chk("state_mid_reset", int'(dut.state), int'(STABLE_LO));
        chk("count_mid_reset", int'(dut.count), 0);
        for (int i = 0; i < 8 + EXTRA; i++)
            step(0, 1, logic'(i >= CHG_AT), logic'(i == CHG_AT), 0);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
